// File: rtl/parity_decode_arbiter_pkg.sv
// Shared codec definitions: code geometry, response status encoding and the
// buffered response record used by the parity decode arbiter.
package codec_pkg;

    localparam int CODE_W   = 24;
    localparam int DATA_W   = 16;
    localparam int NIB      = 4;
    // Widest requester index supported (NUM_REQ up to 4).
    localparam int ID_MAX_W = 2;

    typedef enum logic [1:0] {
        ST_CLEAN  = 2'b00,
        ST_CORR   = 2'b01,
        ST_CHK    = 2'b10,
        ST_UNCORR = 2'b11
    } dec_status_t;

    typedef struct packed {
        logic [ID_MAX_W-1:0] id;
        logic [DATA_W-1:0]   data;
        dec_status_t         status;
    } dec_rsp_t;

    // Number of set bits in a 4-bit syndrome vector.
    function automatic logic [2:0] popcount4(input logic [3:0] x);
        return 3'(x[0]) + 3'(x[1]) + 3'(x[2]) + 3'(x[3]);
    endfunction

endpackage

// File: rtl/parity_decode_arbiter_syndrome.sv
// Combinational 2-D parity syndrome and error classification for one codeword.
// Code layout: [15:0] data as a 4x4 nibble grid, [19:16] row parity,
// [23:20] column parity.
module parity_syndrome_calc
    import codec_pkg::*;
(
    input  logic [CODE_W-1:0] code_i,
    output logic [NIB-1:0]    h_o,
    output logic [NIB-1:0]    v_o,
    output dec_status_t       status_o
);

    logic [2:0] h_cnt;
    logic [2:0] v_cnt;

    // Row (H) and column (V) parity checks against the stored check bits.
    always_comb begin
        h_o = '0;
        v_o = '0;
        for (int i = 0; i < NIB; i++) begin
            h_o[i] = (^code_i[NIB*i +: NIB]) ^ code_i[DATA_W + i];
        end
        for (int j = 0; j < NIB; j++) begin
            v_o[j] = code_i[j] ^ code_i[j+4] ^ code_i[j+8] ^ code_i[j+12]
                   ^ code_i[DATA_W + NIB + j];
        end
    end

    // Classify: one row + one column miss is a single data bit; a lone row or
    // column miss is a flipped check bit; anything else cannot be corrected.
    always_comb begin
        h_cnt    = popcount4(h_o);
        v_cnt    = popcount4(v_o);
        status_o = ST_UNCORR;
        if (h_cnt == 3'd0 && v_cnt == 3'd0) begin
            status_o = ST_CLEAN;
        end else if (h_cnt == 3'd1 && v_cnt == 3'd1) begin
            status_o = ST_CORR;
        end else if ((h_cnt == 3'd1 && v_cnt == 3'd0) ||
                     (h_cnt == 3'd0 && v_cnt == 3'd1)) begin
            status_o = ST_CHK;
        end
    end

endmodule

// File: rtl/parity_decode_arbiter.sv
// Round-robin front end for a shared registered 2-D parity decoder.
// Handshakes: a requester transfers a codeword in any cycle where
// req_valid[i] & req_ready[i]; a response transfers when rsp_valid & rsp_ready.
// req_ready is only raised when the response FIFO is guaranteed room for the
// result two cycles later (credit counts FIFO entries plus the flight slot).
module parity_decode_arbiter
    import codec_pkg::*;
#(
    parameter  int NUM_REQ   = 2,
    parameter  int OUT_DEPTH = 2,
    parameter  int CNT_W     = 16,
    localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*CODE_W-1:0] req_code,
    output logic [CODE_W-1:0]         dec_data_in,
    input  logic [DATA_W-1:0]         dec_data_out,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [1:0]                rsp_status,
    input  logic                      cnt_clr,
    output logic [CNT_W-1:0]          cnt_corrected,
    output logic [CNT_W-1:0]          cnt_uncorr
);

    localparam int PTR_W  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int FCNT_W = $clog2(OUT_DEPTH + 1);
    localparam int OCC_W  = FCNT_W + 2;

    // Arbiter / issue state
    logic [ID_W-1:0]   rr_q, rr_d;
    logic [CODE_W-1:0] last_code_q;
    logic              f_valid_q;
    logic [ID_W-1:0]   f_id_q;
    dec_status_t       f_status_q;

    // Response FIFO state
    dec_rsp_t          mem_q [OUT_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [FCNT_W-1:0] count_q, count_d;

    // Error counters
    logic [CNT_W-1:0]  cnt_corr_q, cnt_corr_d;
    logic [CNT_W-1:0]  cnt_uncorr_q, cnt_uncorr_d;

    logic              push, pop;
    logic [OCC_W-1:0]  occ;
    logic              issue_ok;
    logic              found;
    logic              grant;
    int                cand;
    logic [ID_W-1:0]   gnt_idx;
    logic [CODE_W-1:0] gnt_code;
    logic [NIB-1:0]    syn_h, syn_v;
    dec_status_t       gnt_status;
    dec_rsp_t          head;
    logic              corr_inc, uncorr_inc;
    logic              syn_unused;

    assign rsp_valid = (count_q != '0);
    assign pop       = rsp_valid & rsp_ready;
    assign push      = f_valid_q;

    // Credit: entries held or still in flight, less what leaves this cycle.
    always_comb begin
        occ      = OCC_W'(count_q) + OCC_W'(f_valid_q) - OCC_W'(pop);
        issue_ok = rst_n && (occ < OCC_W'(OUT_DEPTH));
    end

    // Round-robin search: first valid requester at or after rr_q, wrapping.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        cand    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (int'(rr_q) + k) % NUM_REQ;
            if (!found && req_valid[cand]) begin
                found   = 1'b1;
                gnt_idx = ID_W'(cand);
            end
        end
    end

    assign grant    = found & issue_ok;
    assign gnt_code = req_code[int'(gnt_idx)*CODE_W +: CODE_W];

    // Grant strobe and decoder drive; decoder input holds when idle to avoid toggling.
    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready[gnt_idx] = 1'b1;
        end
        dec_data_in = grant ? gnt_code : last_code_q;
        rr_d        = rr_q;
        if (grant) begin
            rr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    parity_syndrome_calc u_syndrome (
        .code_i   (gnt_code),
        .h_o      (syn_h),
        .v_o      (syn_v),
        .status_o (gnt_status)
    );

    // Arbiter pointer, held decoder input and the one-deep flight stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q        <= '0;
            last_code_q <= '0;
            f_valid_q   <= 1'b0;
            f_id_q      <= '0;
            f_status_q  <= ST_CLEAN;
        end else begin
            rr_q      <= rr_d;
            f_valid_q <= grant;
            if (grant) begin
                last_code_q <= gnt_code;
                f_id_q      <= gnt_idx;
                f_status_q  <= gnt_status;
            end
        end
    end

    // FIFO pointer/occupancy next state; pointers wrap at OUT_DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(OUT_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(OUT_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // FIFO control registers; reset discards everything buffered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage: merge flight tag/class with the decoder's corrected data.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{id:     ID_MAX_W'(f_id_q),
                                 data:   dec_data_out,
                                 status: f_status_q};
        end
    end

    assign head       = mem_q[rd_ptr_q];
    assign rsp_id     = head.id[ID_W-1:0];
    assign rsp_data   = head.data;
    assign rsp_status = head.status;
    assign syn_unused = ^{syn_h, syn_v, head.id};

    // Saturating counter next state; clear wins over a same-cycle push.
    always_comb begin
        corr_inc     = push && (f_status_q == ST_CORR || f_status_q == ST_CHK);
        uncorr_inc   = push && (f_status_q == ST_UNCORR);
        cnt_corr_d   = cnt_corr_q;
        cnt_uncorr_d = cnt_uncorr_q;
        if (cnt_clr) begin
            cnt_corr_d   = '0;
            cnt_uncorr_d = '0;
        end else begin
            if (corr_inc && cnt_corr_q != '1) begin
                cnt_corr_d = cnt_corr_q + 1'b1;
            end
            if (uncorr_inc && cnt_uncorr_q != '1) begin
                cnt_uncorr_d = cnt_uncorr_q + 1'b1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_corr_q   <= '0;
            cnt_uncorr_q <= '0;
        end else begin
            cnt_corr_q   <= cnt_corr_d;
            cnt_uncorr_q <= cnt_uncorr_d;
        end
    end

    assign cnt_corrected = cnt_corr_q;
    assign cnt_uncorr    = cnt_uncorr_q;

endmodule

// File: tb/tb_parity_decode_arbiter.sv
// Directed bench for parity_decode_arbiter with a behavioural registered
// 2-D parity decoder attached to the decoder port pair.
module tb_parity_decode_arbiter;

    localparam int NUM_REQ = 2;
    localparam int CNT_W   = 16;

    logic                 clk;
    logic                 rst_n;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ*24-1:0] req_code;
    logic [23:0]          dec_data_in;
    logic [15:0]          dec_data_out;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [0:0]           rsp_id;
    logic [15:0]          rsp_data;
    logic [1:0]           rsp_status;
    logic                 cnt_clr;
    logic [CNT_W-1:0]     cnt_corrected;
    logic [CNT_W-1:0]     cnt_uncorr;

    int tests;
    int fails;

    parity_decode_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .OUT_DEPTH (2),
        .CNT_W     (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_code      (req_code),
        .dec_data_in   (dec_data_in),
        .dec_data_out  (dec_data_out),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_data      (rsp_data),
        .rsp_status    (rsp_status),
        .cnt_clr       (cnt_clr),
        .cnt_corrected (cnt_corrected),
        .cnt_uncorr    (cnt_uncorr)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural decoder: corrects a single data bit, else passes data through.
    function automatic logic [15:0] dec_model(input logic [23:0] c);
        logic [3:0]  h;
        logic [3:0]  v;
        logic [15:0] d;
        int          hi;
        int          vi;
        int          hn;
        int          vn;
        d  = c[15:0];
        hn = 0;
        vn = 0;
        hi = 0;
        vi = 0;
        for (int i = 0; i < 4; i++) begin
            h[i] = c[4*i] ^ c[4*i+1] ^ c[4*i+2] ^ c[4*i+3] ^ c[16+i];
            v[i] = c[i] ^ c[i+4] ^ c[i+8] ^ c[i+12] ^ c[20+i];
            if (h[i]) begin hn++; hi = i; end
            if (v[i]) begin vn++; vi = i; end
        end
        if (hn == 1 && vn == 1) d[4*hi+vi] = ~d[4*hi+vi];
        return d;
    endfunction

    always @(posedge clk) dec_data_out <= dec_model(dec_data_in);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One transaction from requester r, then check the response two cycles later.
    task automatic txn(input int r, input logic [23:0] code, input logic [15:0] exp_data,
                       input logic [1:0] exp_st, input logic clr_on_push);
        int n;
        @(posedge clk); #1;
        req_code[r*24 +: 24] = code;
        req_valid[r] = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready[r] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("grant_seen", 32'(req_ready[r]), 32'd1);
        @(posedge clk); #1;
        req_valid[r] = 1'b0;
        cnt_clr = clr_on_push;
        @(negedge clk);
        check("rsp_not_yet", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        @(negedge clk);
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("rsp_id", 32'(rsp_id), 32'(r));
        check("rsp_data", 32'(rsp_data), 32'(exp_data));
        check("rsp_status", 32'(rsp_status), 32'(exp_st));
    endtask

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    logic [1:0] exp_rdy6 [9];
    logic       exp_rv6  [9];
    logic       exp_id6  [9];

    initial begin
        tests     = 0;
        fails     = 0;
        rst_n     = 1'b0;
        req_valid = 2'b11;
        req_code  = {24'h210002, 24'h110001};
        rsp_ready = 1'b1;
        cnt_clr   = 1'b0;
        exp_rdy6  = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b01};
        exp_rv6   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        exp_id6   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        // Reset state, with requests pending that must not be granted
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_cnt_corr", 32'(cnt_corrected), 32'd0);
        check("rst_cnt_uncorr", 32'(cnt_uncorr), 32'd0);
        check("rst_dec_in", 32'(dec_data_in), 32'd0);
        @(posedge clk); #1;
        req_valid = 2'b00;
        rst_n = 1'b1;

        // 1: clean word from R0
        txn(0, 24'h110001, 16'h0001, 2'b00, 1'b0);
        check("t1_cnt_corr", 32'(cnt_corrected), 32'd0);
        check("t1_cnt_uncorr", 32'(cnt_uncorr), 32'd0);
        check("t1_dec_hold", 32'(dec_data_in), 32'h110001);

        // 2: single data bit error from R1
        txn(1, 24'h110021, 16'h0001, 2'b01, 1'b0);
        check("t2_cnt_corr", 32'(cnt_corrected), 32'd1);

        // 3: check-bit error from R0
        txn(0, 24'h150001, 16'h0001, 2'b10, 1'b0);
        check("t3_cnt_corr", 32'(cnt_corrected), 32'd2);
        check("t3_cnt_uncorr", 32'(cnt_uncorr), 32'd0);

        // 4: double error from R1, data passes through
        txn(1, 24'h110020, 16'h0020, 2'b11, 1'b0);
        check("t4_cnt_uncorr", 32'(cnt_uncorr), 32'd1);
        check("t4_cnt_corr", 32'(cnt_corrected), 32'd2);

        // 5: both requesters streaming, one response per cycle
        req_code = {24'h210002, 24'h110001};
        for (int i = 0; i < 11; i++) begin
            @(posedge clk); #1;
            req_valid = (i < 8) ? 2'b11 : 2'b00;
            @(negedge clk);
            check("t5_req_ready", 32'(req_ready),
                  (i < 8) ? ((i % 2 == 0) ? 32'd1 : 32'd2) : 32'd0);
            check("t5_rsp_valid", 32'(rsp_valid), (i >= 2 && i < 10) ? 32'd1 : 32'd0);
            if (i >= 2 && i < 10) begin
                check("t5_rsp_id", 32'(rsp_id), 32'(i % 2));
                check("t5_rsp_data", 32'(rsp_data), (i % 2 == 0) ? 32'h0001 : 32'h0002);
            end
        end
        check("t5_cnt_corr", 32'(cnt_corrected), 32'd2);
        check("t5_cnt_uncorr", 32'(cnt_uncorr), 32'd1);

        // 6: backpressure for 6 cycles, then drain in order
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            req_valid = 2'b11;
            rsp_ready = (i >= 6);
            @(negedge clk);
            check("t6_req_ready", 32'(req_ready), 32'(exp_rdy6[i]));
            check("t6_rsp_valid", 32'(rsp_valid), 32'(exp_rv6[i]));
            if (exp_rv6[i]) begin
                check("t6_rsp_id", 32'(rsp_id), 32'(exp_id6[i]));
            end
        end

        // Reset mid-stream
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_req_ready", 32'(req_ready), 32'd0);
        check("mid_rst_cnt_corr", 32'(cnt_corrected), 32'd0);
        check("mid_rst_cnt_uncorr", 32'(cnt_uncorr), 32'd0);
        check("mid_rst_dec_in", 32'(dec_data_in), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_grant", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        check("post_rst_rsp_gap", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check("post_rst_rsp_valid", 32'(rsp_valid), 32'd1);
        check("post_rst_rsp_id", 32'(rsp_id), 32'd0);
        check("post_rst_rsp_data", 32'(rsp_data), 32'h0001);

        // 7: clear beats a same-cycle increment, counting resumes afterwards
        txn(1, 24'h110020, 16'h0020, 2'b11, 1'b1);
        check("t7_clr_priority", 32'(cnt_uncorr), 32'd0);
        txn(0, 24'h110020, 16'h0020, 2'b11, 1'b0);
        check("t7_count_resume", 32'(cnt_uncorr), 32'd1);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
